// File: rtl/rc_pulse_train_gen.sv
// rc_pulse_train_gen
//
// Serial RC pulse-train generator for a multi-channel motor controller. Each frame emits
// NUM_CH servo-style pulses back to back on one pin, separated by fixed low gaps. Channel
// levels are slew limited once per frame, a command watchdog ramps every channel to
// neutral when commands stop arriving, and a sticky flag records frames that ran out of
// time before all pulses were emitted.
//
// Ports
//   CLK          system clock
//   RST          synchronous active-high reset
//   CMD          per-channel command, channel k at [k*(MAG_W+2) +: MAG_W+2]:
//                [1:0] dir (00 fwd, 10 rev, 01/11 neutral), [MAG_W+1:2] magnitude
//   CMD_VALID    one-cycle strobe capturing all of CMD
//   PWM          registered serial pulse train
//   FRAME_START  high for the cycle in which the frame counter is 0
//   TIMEOUT      watchdog tripped
//   OVERRUN      sticky; a frame ended before all pulses were emitted

module rc_pulse_train_gen #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned MAG_W          = 3,
    parameter int unsigned FRAME_CYCLES   = 1200000,
    parameter int unsigned NEUTRAL_CYCLES = 150000,
    parameter int unsigned STEP_CYCLES    = 3125,
    parameter int unsigned GAP_CYCLES     = 120000,
    parameter int unsigned SLEW_MAX       = 1,
    parameter int unsigned TIMEOUT_FRAMES = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*(MAG_W+2)-1:0] CMD,
    input  logic                        CMD_VALID,
    output logic                        PWM,
    output logic                        FRAME_START,
    output logic                        TIMEOUT,
    output logic                        OVERRUN
);

    localparam int unsigned CMD_W = MAG_W + 2;
    // Levels span +/-2^MAG_W, so one sign bit on top of MAG_W+1 magnitude bits.
    localparam int unsigned LVL_W = MAG_W + 2;
    localparam int unsigned FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned CW    = $clog2(FRAME_CYCLES) + 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_FRAMES + 1) + 1;

    localparam int                       SLEW_I = int'(SLEW_MAX);
    localparam logic signed [LVL_W-1:0] SLEW_L = LVL_W'(SLEW_MAX);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPulse = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    // Signed target level for one channel command field.
    function automatic logic signed [LVL_W-1:0] decode(input logic [CMD_W-1:0] f);
        logic signed [LVL_W-1:0] mag1;
        logic signed [LVL_W-1:0] res;
        mag1 = $signed(LVL_W'(f[CMD_W-1:2]) + LVL_W'(1));
        case (f[1:0])
            2'b00:   res = mag1;
            2'b10:   res = -mag1;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [CW-1:0] width_of(input logic signed [LVL_W-1:0] lvl);
        int w;
        w = int'(NEUTRAL_CYCLES) + int'(lvl) * int'(STEP_CYCLES);
        return CW'(w);
    endfunction

    // ------------------------------------------------------------------ frame counter
    logic [FC_W-1:0] frame_cnt_q;
    logic            frame_start;
    logic            frame_wrap;

    // Masked by RST so the counter sitting at 0 during reset does not flag a frame.
    assign frame_start = (frame_cnt_q == '0) && !RST;
    assign frame_wrap  = (frame_cnt_q == FC_W'(FRAME_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + FC_W'(1);
        end
    end

    // ------------------------------------------------------------------ watchdog
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            trip_d;

    always_comb begin
        wd_d = wd_q;
        if (CMD_VALID) begin
            wd_d = '0;
        end else if (frame_start && (wd_q != WD_W'(TIMEOUT_FRAMES))) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    assign trip_d = (TIMEOUT_FRAMES != 0) && (wd_d == WD_W'(TIMEOUT_FRAMES));

    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_q <= WD_W'(TIMEOUT_FRAMES);
        end else begin
            wd_q <= wd_d;
        end
    end

    assign TIMEOUT = (TIMEOUT_FRAMES != 0) && (wd_q == WD_W'(TIMEOUT_FRAMES));

    // ------------------------------------------------------------------ targets and levels
    logic signed [LVL_W-1:0] target_q   [NUM_CH];
    logic signed [LVL_W-1:0] level_q    [NUM_CH];
    logic signed [LVL_W-1:0] level_next [NUM_CH];
    logic signed [LVL_W-1:0] cmd_level  [NUM_CH];
    logic signed [LVL_W:0]   diff       [NUM_CH];

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            cmd_level[k] = decode(CMD[k*CMD_W +: CMD_W]);
            diff[k] = {target_q[k][LVL_W-1], target_q[k]} - {level_q[k][LVL_W-1], level_q[k]};
            if ((SLEW_MAX == 0) || ((int'(diff[k]) <= SLEW_I) && (int'(diff[k]) >= -SLEW_I))) begin
                level_next[k] = target_q[k];
            end else if (diff[k] > 0) begin
                level_next[k] = level_q[k] + SLEW_L;
            end else begin
                level_next[k] = level_q[k] - SLEW_L;
            end
        end
    end

    // A capture in the frame-start cycle lands in target_q at the same edge the levels
    // step, so it only influences the following frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= '0;
                level_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (CMD_VALID) begin
                    target_q[k] <= cmd_level[k];
                end else if (trip_d) begin
                    target_q[k] <= '0;
                end
                if (frame_start) begin
                    level_q[k] <= level_next[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------ sequencer
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] ch_d;
    logic [CH_W-1:0] ch_inc;
    logic [CW-1:0]   timer_q;
    logic [CW-1:0]   timer_d;
    logic            pwm_q;
    logic            pwm_d;
    logic            overrun_q;
    logic            overrun_d;
    logic [CW-1:0]   width_first;
    logic [CW-1:0]   width_nextch;

    assign ch_inc = ch_q + CH_W'(1);
    // Channel 0 loads in the same cycle the levels step, so it needs the new level.
    assign width_first  = width_of(level_next[0]);
    assign width_nextch = width_of(level_q[ch_inc]);

    // timer_q counts the remaining cycles of the current pulse or gap, down to 0.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        timer_d   = timer_q;
        pwm_d     = pwm_q;
        overrun_d = overrun_q;
        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StPulse;
                    ch_d    = '0;
                    timer_d = width_first - CW'(1);
                    pwm_d   = 1'b1;
                end
            end
            StPulse: begin
                if (timer_q == '0) begin
                    pwm_d = 1'b0;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        timer_d = CW'(GAP_CYCLES - 1);
                    end
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
            StGap: begin
                if (timer_q == '0) begin
                    state_d = StPulse;
                    ch_d    = ch_inc;
                    timer_d = width_nextch - CW'(1);
                    pwm_d   = 1'b1;
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                pwm_d   = 1'b0;
            end
        endcase
        // A last pulse finishing exactly on the wrap is complete, not an overrun.
        if (frame_wrap && (state_q != StIdle) && (state_d != StIdle)) begin
            state_d   = StIdle;
            pwm_d     = 1'b0;
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            timer_q   <= '0;
            pwm_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            timer_q   <= timer_d;
            pwm_q     <= pwm_d;
            overrun_q <= overrun_d;
        end
    end

    assign PWM         = pwm_q;
    assign FRAME_START = frame_start;
    assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_rc_pulse_train_gen.sv
// Testbench for rc_pulse_train_gen: directed frames followed by random commands, with a
// frame-level reference model feeding a scoreboard that a separate monitor drains. A
// second instance with a long gap exercises the overrun path.

module tb_rc_pulse_train_gen;

    localparam int NUM_CH  = 2;
    localparam int MAG_W   = 3;
    localparam int FC      = 2000;
    localparam int NEUT    = 150;
    localparam int STEP    = 10;
    localparam int GAP     = 40;
    localparam int SLEW    = 2;
    localparam int TF      = 3;
    localparam int GAP_OVR = 1800;
    localparam int FW      = MAG_W + 2;
    localparam int CMD_W   = NUM_CH * FW;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic [CMD_W-1:0] cmd       = '0;
    logic             cmd_valid = 1'b0;
    logic             pwm;
    logic             frame_start;
    logic             timeout;
    logic             overrun;

    logic [CMD_W-1:0] o_cmd       = {NUM_CH{5'b00001}};
    logic             o_cmd_valid = 1'b0;
    logic             o_pwm;
    logic             o_frame_start;
    logic             o_timeout;
    logic             o_overrun;

    always #5 clk = ~clk;

    rc_pulse_train_gen #(
        .NUM_CH(NUM_CH), .MAG_W(MAG_W), .FRAME_CYCLES(FC), .NEUTRAL_CYCLES(NEUT),
        .STEP_CYCLES(STEP), .GAP_CYCLES(GAP), .SLEW_MAX(SLEW), .TIMEOUT_FRAMES(TF)
    ) u_dut (
        .CLK(clk), .RST(rst), .CMD(cmd), .CMD_VALID(cmd_valid),
        .PWM(pwm), .FRAME_START(frame_start), .TIMEOUT(timeout), .OVERRUN(overrun)
    );

    rc_pulse_train_gen #(
        .NUM_CH(NUM_CH), .MAG_W(MAG_W), .FRAME_CYCLES(FC), .NEUTRAL_CYCLES(NEUT),
        .STEP_CYCLES(STEP), .GAP_CYCLES(GAP_OVR), .SLEW_MAX(SLEW), .TIMEOUT_FRAMES(TF)
    ) u_ovr (
        .CLK(clk), .RST(rst), .CMD(o_cmd), .CMD_VALID(o_cmd_valid),
        .PWM(o_pwm), .FRAME_START(o_frame_start), .TIMEOUT(o_timeout), .OVERRUN(o_overrun)
    );

    typedef struct {
        int start;
        int width;
    } pulse_t;

    typedef struct {
        bit fs;
        bit tmo;
    } cyc_t;

    pulse_t pulse_q[$];
    cyc_t   cyc_q[$];

    int checks = 0;
    int errors = 0;
    int t      = 0;
    int epoch  = 0;
    bit mon_en = 1'b0;

    int m_target[NUM_CH];
    int m_level[NUM_CH];
    int m_wd;

    int mon_off   = -1;
    int mon_start = 0;
    int mon_len   = 0;
    bit mon_prev  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_target[k] = 0;
            m_level[k]  = 0;
        end
        m_wd = TF;
    endtask

    // Frame-level reference: one call per cycle, before that cycle's edge.
    task automatic model_cycle(input bit v, input logic [CMD_W-1:0] c);
        cyc_t             e;
        pulse_t           p;
        int               off;
        int               diff;
        bit               fs;
        logic [FW-1:0]    f;
        fs    = ((t % FC) == 0);
        e.fs  = fs;
        e.tmo = (m_wd == TF);
        cyc_q.push_back(e);
        if (fs) begin
            off = 1;
            for (int k = 0; k < NUM_CH; k++) begin
                diff = m_target[k] - m_level[k];
                if (diff > SLEW) m_level[k] += SLEW;
                else if (diff < -SLEW) m_level[k] -= SLEW;
                else m_level[k] = m_target[k];
                p.start = off;
                p.width = NEUT + m_level[k] * STEP;
                pulse_q.push_back(p);
                off += p.width + GAP;
            end
        end
        if (v) begin
            for (int k = 0; k < NUM_CH; k++) begin
                f = c[k*FW +: FW];
                case (f[1:0])
                    2'b00:   m_target[k] = int'(f[FW-1:2]) + 1;
                    2'b10:   m_target[k] = -(int'(f[FW-1:2]) + 1);
                    default: m_target[k] = 0;
                endcase
            end
            m_wd = 0;
        end else if (fs) begin
            if (m_wd < TF) m_wd++;
            if (m_wd == TF) begin
                for (int k = 0; k < NUM_CH; k++) m_target[k] = 0;
            end
        end
    endtask

    // Long-gap instance: pulse 1 cannot finish inside the frame.
    task automatic ovr_checks();
        if (epoch == 0) begin
            if (t == 150) check("ovr_pulse0_last_high", int'(o_pwm), 1);
            if (t == 151) check("ovr_gap_low", int'(o_pwm), 0);
            if (t == 1950) check("ovr_gap_end_low", int'(o_pwm), 0);
            if (t == FC - 1) check("ovr_flag_before_wrap", int'(o_overrun), 0);
            if (t == FC) begin
                check("ovr_pwm_low_at_wrap", int'(o_pwm), 0);
                check("ovr_flag_set", int'(o_overrun), 1);
                check("ovr_frame_start", int'(o_frame_start), 1);
            end
            if (t == FC + 1) check("ovr_new_frame_pulse", int'(o_pwm), 1);
            if (t == 5 * FC + 7) check("ovr_flag_sticky", int'(o_overrun), 1);
        end
    endtask

    // Called at posedge+#1: drives cycle t and advances to cycle t+1.
    task automatic cycle(input bit v, input logic [CMD_W-1:0] c);
        cmd_valid   = v;
        cmd         = c;
        o_cmd_valid = (epoch == 0) && (t == 5);
        ovr_checks();
        model_cycle(v, c);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_frame(input int at, input logic [CMD_W-1:0] c);
        for (int i = 0; i < FC; i++) begin
            if (i == at) cycle(1'b1, c);
            else cycle(1'b0, CMD_W'($urandom));
        end
    endtask

    // Monitor: per-cycle FRAME_START/TIMEOUT, and every completed PWM pulse.
    initial begin
        cyc_t   e;
        pulse_t p;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mon_off  = -1;
                mon_prev = 1'b0;
                mon_len  = 0;
            end else begin
                if (cyc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cycle_expectation at t=%0d: monitor ran ahead of the model", t);
                end else begin
                    e = cyc_q.pop_front();
                    check("frame_start", int'(frame_start), int'(e.fs));
                    check("timeout", int'(timeout), int'(e.tmo));
                    check("overrun", int'(overrun), 0);
                end
                if (frame_start) mon_off = 0;
                else if (mon_off >= 0) mon_off++;
                if (pwm && !mon_prev) begin
                    mon_start = mon_off;
                    mon_len   = 1;
                end else if (pwm) begin
                    mon_len++;
                end else if (mon_prev) begin
                    if (pulse_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse at t=%0d: width %0d, none expected", t, mon_len);
                    end else begin
                        p = pulse_q.pop_front();
                        check("pulse_start", mon_start, p.start);
                        check("pulse_width", mon_len, p.width);
                    end
                end
                mon_prev = pwm;
            end
        end
    end

    initial begin
        int r;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", int'(pwm), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_timeout", int'(timeout), 1);
        check("rst_overrun", int'(overrun), 0);
        check("rst_ovr_overrun", int'(o_overrun), 0);

        rst    = 1'b0;
        mon_en = 1'b1;
        run_frame(-1, '0);                          // neutral, watchdog tripped
        run_frame(700, {5'b00010, 5'b01100});       // ch0 fwd 3, ch1 rev 0
        repeat (5) run_frame(-1, '0);               // ramp up, trip, ramp to neutral
        run_frame(0, {5'b00001, 5'b00000});         // capture in the frame-start cycle
        run_frame(-1, '0);

        for (int f = 0; f < 26; f++) begin
            r = $urandom_range(0, 9);
            if (r < 3) run_frame(-1, '0);
            else if (r == 3) run_frame(0, CMD_W'($urandom));
            else run_frame($urandom_range(1, FC - 1), CMD_W'($urandom));
        end
        check("pulses_left_before_reset", pulse_q.size(), 0);

        // Reset in the middle of the channel 0 pulse.
        for (int i = 0; i < 50; i++) cycle(1'b0, '0);
        check("pwm_high_before_reset", int'(pwm), 1);
        mon_en      = 1'b0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        o_cmd_valid = 1'b0;
        pulse_q.delete();
        cyc_q.delete();
        @(posedge clk);
        #1;
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_frame_start", int'(frame_start), 0);
        check("midrst_timeout", int'(timeout), 1);
        check("midrst_ovr_overrun", int'(o_overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        t      = 0;
        epoch  = 1;
        mon_en = 1'b1;
        run_frame(-1, '0);
        check("pulses_left_at_end", pulse_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc_pulse_train_gen.md
Name: rc_pulse_train_gen

Overview:
- Parametrised successor to the two-motor pulse generator.
- Emits one serial RC pulse train on a single pin: NUM_CH servo-style pulses back to back each frame, for a Mode-2 style multi-channel motor controller.
- Adds over the previous generation: arbitrary channel count and magnitude width, per-frame slew limiting, a command watchdog that ramps all channels to neutral, and an overrun flag.
- Sits between the navigation command logic and the motor-controller output pin.

Parameters:
NUM_CH, 2, number of channels serialised per frame
MAG_W, 3, magnitude bits per channel command
FRAME_CYCLES, 1200000, frame period in clocks (12 ms at 100 MHz)
NEUTRAL_CYCLES, 150000, neutral pulse width (1.5 ms)
STEP_CYCLES, 3125, width change per level step
GAP_CYCLES, 120000, low time between end of pulse k and start of pulse k+1
SLEW_MAX, 1, max level change per channel per frame; 0 = unlimited
TIMEOUT_FRAMES, 8, frame starts without CMD_VALID before watchdog trips; 0 = watchdog disabled

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
CMD  in  NUM_CH*(MAG_W+2)  channel k at bits [k*(MAG_W+2) +: MAG_W+2]; [1:0] = dir (00 fwd, 01 neutral, 10 rev, 11 neutral); [MAG_W+1:2] = magnitude
CMD_VALID  in  1  one-cycle strobe; captures all of CMD
PWM  out  1  serial pulse train
FRAME_START  out  1  high for one cycle when the frame counter is 0
TIMEOUT  out  1  watchdog tripped
OVERRUN  out  1  sticky; a frame ended before all pulses were emitted

Behaviour:
- Reset: clock only. During RST: frame counter = 0; all target and current levels = 0; FSM = IDLE; watchdog counter = TIMEOUT_FRAMES. Outputs: PWM = 0, FRAME_START = 0, TIMEOUT = 1 (or 0 if TIMEOUT_FRAMES = 0), OVERRUN = 0.
- Reset mid-pulse: PWM = 0 the cycle after RST is sampled.
- Frame counter: runs 0..FRAME_CYCLES-1, then wraps. It is 0 on the first cycle after RST deasserts.
- Command decode on CMD_VALID, to the signed target level per channel:
  - fwd: +(mag+1)
  - rev: -(mag+1)
  - 01 or 11: 0
  - Level range is +/-2^MAG_W.
- Frame start (counter = 0), for each channel, using target values registered before this edge:
  - Current level moves toward target by min(|diff|, SLEW_MAX), or jumps to target when SLEW_MAX = 0.
  - Width W_k = NEUTRAL_CYCLES + level*STEP_CYCLES.
  - Widths are frozen for the whole frame.
- CMD_VALID in the frame-start cycle: the capture takes effect at the following frame start.
- Sequencer FSM: IDLE -> PULSE(k) -> GAP -> PULSE(k+1) ... -> PULSE(NUM_CH-1) -> IDLE. There is no trailing gap.
  - IDLE -> PULSE(0) on the frame-start cycle.
  - PWM is registered. It is high for exactly W_k consecutive cycles per pulse; the first high cycle is the one after the frame-start cycle.
  - Gaps are exactly GAP_CYCLES low.
- Overrun: if the counter wraps while FSM != IDLE:
  - PWM is forced low and the remaining pulses are dropped.
  - OVERRUN is set and stays set until RST.
  - The new frame starts normally.
- Watchdog:
  - CMD_VALID reloads the counter to 0 and clears TIMEOUT on the next cycle.
  - Each frame start without CMD_VALID increments the counter, saturating.
  - At TIMEOUT_FRAMES the watchdog trips: TIMEOUT = 1 and all targets are forced to 0. Levels then ramp to neutral at the SLEW_MAX rate.
  - Pulses continue at neutral so the controller stays armed.
- Width arithmetic: computed in clog2(FRAME_CYCLES)+1 bits. At defaults with MAG_W = 3, widths span 125000..175000.

Test Plan:
All scenarios use scaled parameters unless stated: FRAME_CYCLES 2000, NEUTRAL 150, STEP 10, GAP 40, NUM_CH 2, SLEW_MAX 2, TIMEOUT_FRAMES 3.
1. Reset, no command -> FRAME_START every 2000 cycles; each frame PWM is 150 high, 40 low, 150 high, then low to frame end; TIMEOUT = 1.
2. CMD_VALID with ch0 fwd mag 3 and ch1 rev mag 0 -> next frame ch0 = 170, ch1 = 140; following frame ch0 = 190, ch1 = 140; TIMEOUT = 0.
3. After scenario 2, no CMD_VALID for 3 frame starts -> TIMEOUT = 1; ch0 width goes 170, then 150; ch1 goes 150.
4. CMD_VALID in the same cycle as FRAME_START (ch0 fwd mag 0) -> that frame ch0 = 150; next frame ch0 = 160.
5. GAP 1800, neutral commands -> ch1 never emitted; PWM low at the wrap; OVERRUN = 1 and held until RST.
6. RST asserted during ch0 high time -> PWM = 0 next cycle; after release, a new neutral frame starts with FRAME_START on the first cycle.
